// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the ALU / load-return sources and the regfile write arbiter.
// The arbiter connects through the slave modport; the sources and regfile side use master.
interface rf_wb_arbiter_if #(
    parameter int unsigned BITS   = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [BITS-1:0]   alu_data;
    logic [3:0]        alu_byte_en;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [BITS-1:0]   ld_data;
    logic [3:0]        ld_byte_en;

    logic              rf_rw_;
    logic [ADDR_W-1:0] rf_waddr;
    logic [BITS-1:0]   rf_wdata;
    logic [3:0]        rf_byte_en;
    logic              ld_pending;

    modport master (
        output alu_valid, alu_addr, alu_data, alu_byte_en,
        output ld_valid, ld_addr, ld_data, ld_byte_en,
        input  alu_ready, ld_ready,
        input  rf_rw_, rf_waddr, rf_wdata, rf_byte_en, ld_pending
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, alu_byte_en,
        input  ld_valid, ld_addr, ld_data, ld_byte_en,
        output alu_ready, ld_ready,
        output rf_rw_, rf_waddr, rf_wdata, rf_byte_en, ld_pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: ALU has fixed priority, loads are FIFO-buffered with a starvation bound.
// Optional combinational write forwarding is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_,
    rf_wb_arbiter_if.slave    bus
`ifdef RF_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [BITS-1:0]   fwd_data
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    function automatic logic [3:0] norm_be(input logic [3:0] be);
        logic [3:0] r;
        case (be)
            4'b0001, 4'b0011, 4'b1111: r = be;
            default:                   r = 4'b1111;
        endcase
        return r;
    endfunction

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [BITS-1:0]   fifo_data [DEPTH];
    logic [3:0]        fifo_be   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [SC_W-1:0]   starve_cnt;

    logic empty;
    logic full;
    logic push;
    logic force_ld;
    logic grant_alu;
    logic grant_ld;

    logic              rf_rw_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [BITS-1:0]   rf_wdata_q;
    logic [3:0]        rf_byte_en_q;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign push   = bus.ld_valid && !full;

    assign force_ld  = (starve_cnt == SC_W'(STARVE_MAX)) && !empty;
    assign grant_alu = bus.alu_valid && !force_ld;
    assign grant_ld  = !grant_alu && !empty;

    assign bus.alu_ready  = !force_ld;
    assign bus.ld_ready   = !full;
    assign bus.ld_pending = !empty;
    assign bus.rf_rw_     = rf_rw_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.rf_byte_en = rf_byte_en_q;

    // Byte enables are normalised on entry so the head and forwarding paths see final values.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= bus.ld_addr;
            fifo_data[wr_idx] <= bus.ld_data;
            fifo_be[wr_idx]   <= norm_be(bus.ld_byte_en);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant_ld)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (grant_ld || empty)
                starve_cnt <= '0;
            else if (grant_alu && starve_cnt != SC_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Writes to register 0 are consumed by the grant but leave rw_ deasserted.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rf_rw_q      <= 1'b1;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_byte_en_q <= '0;
        end else if (grant_alu) begin
            rf_rw_q      <= (bus.alu_addr == '0);
            rf_waddr_q   <= bus.alu_addr;
            rf_wdata_q   <= bus.alu_data;
            rf_byte_en_q <= norm_be(bus.alu_byte_en);
        end else if (grant_ld) begin
            rf_rw_q      <= (fifo_addr[rd_idx] == '0);
            rf_waddr_q   <= fifo_addr[rd_idx];
            rf_wdata_q   <= fifo_data[rd_idx];
            rf_byte_en_q <= fifo_be[rd_idx];
        end else begin
            rf_rw_q <= 1'b1;
        end
    end

`ifdef RF_WB_FWD_EN
    logic [PTR_W-1:0] count;
    logic             q_hit;
    logic [BITS-1:0]  q_data;
    logic [3:0]       q_be;

    assign count = wr_ptr - rd_ptr;

    // Walk oldest to youngest so the last match left standing is the youngest entry.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        q_be   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (PTR_W'(i) < count && fifo_addr[IDX_W'(rd_ptr + PTR_W'(i))] == fwd_addr) begin
                q_hit  = 1'b1;
                q_data = fifo_data[IDX_W'(rd_ptr + PTR_W'(i))];
                q_be   = fifo_be[IDX_W'(rd_ptr + PTR_W'(i))];
            end
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (!rf_rw_q && rf_waddr_q == fwd_addr) begin
                fwd_hit  = (rf_byte_en_q == 4'b1111);
                fwd_data = rf_wdata_q;
            end else if (q_hit) begin
                fwd_hit  = (q_be == 4'b1111);
                fwd_data = q_data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model plus directed scenarios.
// Forwarding checks are compiled in when RF_WB_FWD_EN is defined.
module tb_rf_wb_arbiter;
    localparam int unsigned BITS       = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus();

`ifdef RF_WB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [BITS-1:0]   fwd_data;
`endif

    rf_wb_arbiter #(
        .BITS(BITS), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .bus(bus)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [BITS-1:0]   data;
        logic [3:0]        be;
    } wr_t;

    function automatic logic [3:0] spec_be(input logic [3:0] be);
        return (be == 4'b0001 || be == 4'b0011 || be == 4'b1111) ? be : 4'b1111;
    endfunction

    // Reference model: a queue of pending loads and a count of consecutive ALU wins.
    wr_t         ldq[$];
    int unsigned wins;

    initial begin : compare
        bit          m_empty;
        bit          m_force;
        bit          e_rw;
        int unsigned qsz;
        wr_t         w;
        wins = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_) begin
                ldq.delete();
                wins = 0;
                chk("rst_rw", bus.rf_rw_, 1'b1);
                chk("rst_waddr", bus.rf_waddr, '0);
                chk("rst_wdata", bus.rf_wdata, '0);
                chk("rst_be", bus.rf_byte_en, '0);
                chk("rst_ld_ready", bus.ld_ready, 1'b1);
                chk("rst_pending", bus.ld_pending, 1'b0);
                continue;
            end
            qsz     = ldq.size();
            m_empty = (qsz == 0);
            m_force = (wins >= STARVE_MAX) && !m_empty;
            chk("m_alu_ready", bus.alu_ready, !m_force);
            chk("m_ld_ready", bus.ld_ready, qsz < DEPTH);
            chk("m_pending", bus.ld_pending, !m_empty);
            e_rw = 1'b1;
            if (bus.alu_valid && !m_force) begin
                w    = '{bus.alu_addr, bus.alu_data, bus.alu_byte_en};
                e_rw = (w.addr == 0);
                if (m_empty)              wins = 0;
                else if (wins < STARVE_MAX) wins = wins + 1;
            end else if (!m_empty) begin
                w    = ldq.pop_front();
                e_rw = (w.addr == 0);
                wins = 0;
            end else begin
                wins = 0;
            end
            if (bus.ld_valid && qsz < DEPTH)
                ldq.push_back('{bus.ld_addr, bus.ld_data, bus.ld_byte_en});
            @(posedge clk);
            #1;
            if (rst_) begin
                chk("m_rw", bus.rf_rw_, e_rw);
                if (!e_rw) begin
                    chk("m_waddr", bus.rf_waddr, w.addr);
                    chk("m_wdata", bus.rf_wdata, w.data);
                    chk("m_be", bus.rf_byte_en, spec_be(w.be));
                end
            end
        end
    end

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_addr    = '0;
        bus.alu_data    = '0;
        bus.alu_byte_en = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.ld_byte_en  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic alu(input logic [ADDR_W-1:0] a, input logic [BITS-1:0] d, input logic [3:0] be);
        bus.alu_valid   = 1'b1;
        bus.alu_addr    = a;
        bus.alu_data    = d;
        bus.alu_byte_en = be;
    endtask

    task automatic ld(input logic [ADDR_W-1:0] a, input logic [BITS-1:0] d, input logic [3:0] be);
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = a;
        bus.ld_data    = d;
        bus.ld_byte_en = be;
    endtask

    initial begin : stim
        int              cnt;
        bit              found;
        bit              xfer;
        bit              first;
        int              j;
        int              n_iss;
        int              iss [3];
        logic [ADDR_W-1:0] la;

        idle();
`ifdef RF_WB_FWD_EN
        fwd_addr = '0;
`endif
        // T1 reset
        rst_ = 1'b0;
        step(3);
        chk("t1_rw", bus.rf_rw_, 1'b1);
        chk("t1_be", bus.rf_byte_en, 4'b0000);
        chk("t1_ld_ready", bus.ld_ready, 1'b1);
        chk("t1_pending", bus.ld_pending, 1'b0);
        rst_ = 1'b1;
        step(1);

        // T2 ALU only, latency 1
        alu(5'd5, 32'hDEADBEEF, 4'b1111);
        step(1);
        idle();
        chk("t2_rw", bus.rf_rw_, 1'b0);
        chk("t2_waddr", bus.rf_waddr, 5'd5);
        chk("t2_wdata", bus.rf_wdata, 32'hDEADBEEF);
        step(1);
        chk("t2_idle", bus.rf_rw_, 1'b1);

        // T3 load only, latency 2
        ld(5'd7, 32'h12345678, 4'b1111);
        step(1);
        idle();
        chk("t3_pending", bus.ld_pending, 1'b1);
        chk("t3_early", bus.rf_rw_, 1'b1);
        step(1);
        chk("t3_rw", bus.rf_rw_, 1'b0);
        chk("t3_waddr", bus.rf_waddr, 5'd7);
        chk("t3_wdata", bus.rf_wdata, 32'h12345678);
        chk("t3_pending_clr", bus.ld_pending, 1'b0);
        step(1);
        chk("t3_idle", bus.rf_rw_, 1'b1);

        // T4 starvation bound
        ld(5'd8, 32'h00008888, 4'b1111);
        alu(5'd10, 32'h0000000A, 4'b1111);
        step(1);
        bus.ld_valid = 1'b0;
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!bus.alu_ready) begin
                found = 1'b1;
            end else begin
                if (bus.ld_pending) cnt++;
                bus.alu_addr = 5'(11 + i);
                step(1);
            end
        end
        la = bus.alu_addr;
        chk("t4_forced", found, 1'b1);
        chk("t4_alu_wins", cnt, 4);
        step(1);
        chk("t4_ld_rw", bus.rf_rw_, 1'b0);
        chk("t4_ld_addr", bus.rf_waddr, 5'd8);
        chk("t4_alu_back", bus.alu_ready, 1'b1);
        step(1);
        chk("t4_resume", bus.rf_waddr, la);
        idle();
        step(2);

        // T5 FIFO full, loads held and issued in order
        alu(5'd3, 32'h33, 4'b1111);
        j     = 0;
        n_iss = 0;
        first = 1'b1;
        iss   = '{0, 0, 0};
        for (int c = 0; c < 80 && n_iss < 3; c++) begin
            if (j < 3) ld(5'(20 + j), 32'(32'hA0 + j), 4'b1111);
            else       bus.ld_valid = 1'b0;
            xfer = bus.ld_valid && bus.ld_ready;
            if (j == 2 && first) begin
                chk("t5_full", bus.ld_ready, 1'b0);
                first = 1'b0;
            end
            step(1);
            if (xfer) j++;
            if (!bus.rf_rw_ && bus.rf_waddr >= 5'd20 && bus.rf_waddr <= 5'd22 && n_iss < 3) begin
                iss[n_iss] = int'(bus.rf_waddr);
                n_iss++;
            end
        end
        chk("t5_enq", j, 3);
        chk("t5_issued", n_iss, 3);
        for (int k = 0; k < 3; k++) chk("t5_order", iss[k], 20 + k);
        idle();
        step(3);

        // T6 edge rules
        alu(5'd0, 32'h00000BAD, 4'b1111);
        step(1);
        idle();
        chk("t6_r0_alu", bus.rf_rw_, 1'b1);
        alu(5'd4, 32'h44, 4'b0101);
        step(1);
        idle();
        chk("t6_be0101_rw", bus.rf_rw_, 1'b0);
        chk("t6_be0101", bus.rf_byte_en, 4'b1111);
        alu(5'd6, 32'h66, 4'b0011);
        step(1);
        idle();
        chk("t6_be0011", bus.rf_byte_en, 4'b0011);
        alu(5'd6, 32'h67, 4'b0000);
        step(1);
        idle();
        chk("t6_be0000", bus.rf_byte_en, 4'b1111);
        ld(5'd12, 32'hC, 4'b0001);
        step(1);
        idle();
        step(1);
        chk("t6_ld_be", bus.rf_byte_en, 4'b0001);
        chk("t6_ld_addr", bus.rf_waddr, 5'd12);
        ld(5'd0, 32'hF0, 4'b1111);
        step(1);
        idle();
        chk("t6_r0_pend", bus.ld_pending, 1'b1);
        step(1);
        chk("t6_r0_ld", bus.rf_rw_, 1'b1);
        chk("t6_r0_pop", bus.ld_pending, 1'b0);

`ifdef RF_WB_FWD_EN
        alu(5'd2, 32'h22, 4'b1111);
        ld(5'd9, 32'hAA, 4'b1111);
        step(1);
        bus.ld_valid = 1'b0;
        fwd_addr = 5'd9;
        #1;
        chk("t6_fwd_q_hit", fwd_hit, 1'b1);
        chk("t6_fwd_q_data", fwd_data, 32'hAA);
        fwd_addr = 5'd2;
        #1;
        chk("t6_fwd_r_hit", fwd_hit, 1'b1);
        chk("t6_fwd_r_data", fwd_data, 32'h22);
        fwd_addr = 5'd0;
        #1;
        chk("t6_fwd_r0", fwd_hit, 1'b0);
        idle();
        step(2);
`endif

        // reset with loads buffered: nothing replays
        alu(5'd1, 32'h1, 4'b1111);
        ld(5'd15, 32'hF, 4'b1111);
        step(1);
        ld(5'd16, 32'h10, 4'b1111);
        step(1);
        idle();
        rst_ = 1'b0;
        #1;
        chk("rst_mid_pend", bus.ld_pending, 1'b0);
        chk("rst_mid_rw", bus.rf_rw_, 1'b1);
        step(2);
        rst_ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("rst_no_replay", bus.rf_rw_, 1'b1);
        end

        // mixed traffic checked by the model
        for (int c = 0; c < 60; c++) begin
            bus.alu_valid   = 1'($urandom_range(0, 1));
            bus.alu_addr    = 5'($urandom_range(0, 31));
            bus.alu_data    = $urandom;
            bus.alu_byte_en = 4'($urandom_range(0, 15));
            bus.ld_valid    = 1'($urandom_range(0, 1));
            bus.ld_addr     = 5'($urandom_range(0, 31));
            bus.ld_data     = $urandom;
            bus.ld_byte_en  = 4'($urandom_range(0, 15));
            step(1);
        end
        idle();
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
